// File: rtl/frame_dma_writer.sv
// frame_dma_writer: packs 12-bit Bayer pixel pairs into 32-bit words and writes whole frames to memory in fixed-length bursts
module frame_dma_writer #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          FRAME_WIDTH  = 640,
  parameter int          FRAME_HEIGHT = 480,
  parameter int          BURST_LEN    = 8
)(
  input  logic        piul1Clock,
  input  logic        piul1Reset_n,
  input  logic        piEnable,
  input  logic        piValid,
  output logic        poReady,
  input  logic        piSof,
  input  logic        piEol,
  input  logic [11:0] piData,
  output logic [31:0] poAddr,
  output logic        poWrite,
  output logic [31:0] poWriteData,
  output logic [3:0]  poBurstCount,
  input  logic        piWaitRequest,
  output logic        poBusy,
  output logic        poFrameDone,
  output logic        poErr
);
  localparam int CW = $clog2(FRAME_WIDTH);
  localparam int RW = $clog2(FRAME_HEIGHT + 1);
  typedef enum logic [2:0] {IDLE, WAIT_SOF, CAPTURE, DRAIN, RESYNC} state_t;
  state_t state, state_nxt;
  logic [31:0] mem [16];
  logic [3:0] wr_ptr, rd_ptr, beat;
  logic [4:0] count, count_nxt;
  logic [11:0] even_pix;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic active, en_q, accept, push, pop, last_beat, col_last, row_last, bad, frame_end, out_idle, start_ok;
  assign accept    = piValid & poReady;
  assign col_last  = col == CW'(FRAME_WIDTH - 1);
  assign row_last  = row == RW'(FRAME_HEIGHT - 1);
  assign bad       = piSof | (piEol ^ col_last);
  assign push      = state == CAPTURE && accept && !bad && col[0];
  assign pop       = active & !piWaitRequest;
  assign last_beat = pop && beat == 4'(BURST_LEN - 1);
  assign frame_end = state == CAPTURE && accept && !bad && col_last && row_last;
  assign out_idle  = !active && count == 5'd0;
  assign count_nxt = count + 5'(push) - 5'(pop);
  // Looking at post-edge occupancy lets a new burst follow the previous one with no idle cycle
  assign start_ok  = state != RESYNC && count_nxt >= 5'(BURST_LEN);
  always_ff @(posedge piul1Clock)
    if (!piul1Reset_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     state_nxt = piEnable ? WAIT_SOF : IDLE;
      WAIT_SOF: state_nxt = !piEnable ? IDLE : (accept && piSof) ? CAPTURE : WAIT_SOF;
      CAPTURE:  state_nxt = !accept ? CAPTURE : bad ? RESYNC : frame_end ? DRAIN : CAPTURE;
      DRAIN:    state_nxt = !out_idle ? DRAIN : piEnable ? WAIT_SOF : IDLE;
      RESYNC:   state_nxt = active ? RESYNC : piEnable ? WAIT_SOF : IDLE;
      default:  state_nxt = IDLE;
    endcase
  end
  always_comb begin
    poReady      = state == WAIT_SOF || state == RESYNC || (state == CAPTURE && count != 5'd16);
    poBusy       = state != IDLE;
    poFrameDone  = state == DRAIN && out_idle;
    poWrite      = active;
    poWriteData  = active ? mem[rd_ptr] : 32'h0;
    poBurstCount = 4'(BURST_LEN);
  end
  always_ff @(posedge piul1Clock)
    if (push) mem[wr_ptr] <= {4'h0, piData, 4'h0, even_pix};
  always_ff @(posedge piul1Clock) begin
    if (!piul1Reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      beat     <= '0;
      active   <= 1'b0;
      col      <= '0;
      row      <= '0;
      even_pix <= '0;
      poAddr   <= BASE_ADDR;
      poErr    <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      en_q   <= piEnable;
      count  <= count_nxt;
      active <= (active & !last_beat) | start_ok;
      if (push) wr_ptr <= wr_ptr + 4'd1;
      if (pop) rd_ptr <= rd_ptr + 4'd1;
      if (pop) beat <= last_beat ? 4'd0 : beat + 4'd1;
      if (last_beat) poAddr <= poAddr + 32'(BURST_LEN * 4);
      if (state == WAIT_SOF && accept && piSof) begin
        even_pix <= piData;
        col      <= CW'(1);
        row      <= '0;
      end else if (state == CAPTURE && accept && !bad) begin
        if (!col[0]) even_pix <= piData;
        col <= col_last ? '0 : col + CW'(1);
        if (col_last) row <= row_last ? '0 : row + RW'(1);
      end
      if ((state == IDLE && piEnable) || (state == DRAIN && out_idle)) poAddr <= BASE_ADDR;
      // Abandon the broken frame only once any burst already on the bus has finished
      if (state == RESYNC && !active) begin
        poAddr   <= BASE_ADDR;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        col      <= '0;
        row      <= '0;
        even_pix <= '0;
      end
      if (state == CAPTURE && accept && bad) poErr <= 1'b1;
      else if (piEnable && !en_q) poErr <= 1'b0;
    end
  end
endmodule

// File: tb/tb_frame_dma_writer.sv
// tb_frame_dma_writer: random frames against a word/address queue model, plus stall, framing-error and reset scenarios
module tb_frame_dma_writer;
  localparam int W = 8, H = 6, BL = 4;
  localparam logic [31:0] BASE = 32'h1000;
  logic clk = 0, rst_n = 0, enable = 0, valid = 0, sof = 0, eol = 0, waitreq = 0;
  logic [11:0] data = 0;
  logic ready, write, busy, done, err;
  logic [31:0] addr, wdata;
  logic [3:0] bcount;
  int checks = 0, errors = 0, done_cnt = 0, px_cnt = 0, stall_mode = 0;
  bit gap_en = 0;
  logic [31:0] exp_a[$], exp_d[$];

  frame_dma_writer #(.BASE_ADDR(BASE), .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .BURST_LEN(BL)) dut (
    .piul1Clock(clk), .piul1Reset_n(rst_n), .piEnable(enable), .piValid(valid), .poReady(ready),
    .piSof(sof), .piEol(eol), .piData(data), .poAddr(addr), .poWrite(write), .poWriteData(wdata),
    .poBurstCount(bcount), .piWaitRequest(waitreq), .poBusy(busy), .poFrameDone(done), .poErr(err));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1 waitreq = stall_mode == 2 ? 1'b1 : stall_mode == 1 ? ($urandom_range(0, 2) == 0) : 1'b0;
  end

  always @(negedge clk) if (rst_n) begin
    if (done) done_cnt++;
    if (write && !waitreq) begin
      check("beat_expected", 32'(exp_a.size() != 0), 1);
      if (exp_a.size() != 0) begin
        check("addr", addr, exp_a.pop_front());
        check("data", wdata, exp_d.pop_front());
      end
    end
  end

  task automatic send_pixel(input logic [11:0] d, input logic s, input logic e);
    int n = 0;
    logic rdy;
    if (gap_en) repeat ($urandom_range(0, 2)) begin valid = 0; @(posedge clk); #1; end
    valid = 1; data = d; sof = s; eol = e;
    forever begin
      @(negedge clk) rdy = ready;
      @(posedge clk); #1;
      if (rdy) break;
      if (++n > 3000) begin check("ready_wait", n, 3000); break; end
    end
    valid = 0; sof = 0; eol = 0;
    px_cnt++;
  endtask

  task automatic send_frame();
    logic [11:0] ev = 0, p;
    int k = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        p = 12'($urandom);
        send_pixel(p, r == 0 && c == 0, c == W - 1);
        if (c % 2 == 1) begin
          exp_d.push_back({4'h0, p, 4'h0, ev});
          exp_a.push_back(BASE + 32'((k / BL) * BL * 4));
          k++;
        end else ev = p;
      end
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 3000) begin @(posedge clk); #1; n++; end
    repeat (3) @(posedge clk); #1;
    check("done_cnt", done_cnt, target);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", ready, 0); check("rst_write", write, 0); check("rst_addr", addr, BASE);
    check("rst_wdata", wdata, 0); check("rst_busy", busy, 0); check("rst_done", done, 0);
    check("rst_err", err, 0); check("rst_bcount", bcount, BL);
    @(posedge clk); #1 rst_n = 1; enable = 1;
    send_frame(); wait_done(1);
    check("q_empty_1", exp_a.size(), 0);
    gap_en = 1; stall_mode = 1;
    for (int i = 0; i < 3; i++) send_frame();
    wait_done(4);
    for (int i = 0; i < 3; i++) send_pixel(12'hAAA, 0, 0);
    send_frame(); wait_done(5);
    check("q_empty_2", exp_a.size(), 0);
    gap_en = 0; stall_mode = 0;
    send_pixel(12'h011, 1, 0); send_pixel(12'h022, 0, 0); send_pixel(12'h033, 0, 1);
    repeat (20) @(posedge clk); #1;
    check("err_set", err, 1); check("err_no_done", done_cnt, 5);
    send_frame(); wait_done(6);
    check("err_sticky", err, 1);
    enable = 0; repeat (2) @(posedge clk); #1 enable = 1;
    repeat (2) @(posedge clk); #1;
    check("err_cleared", err, 0);
    stall_mode = 2; px_cnt = 0;
    fork
      begin send_frame(); send_frame(); end
      begin
        repeat (80) @(posedge clk);
        @(negedge clk);
        check("full_ready", ready, 0); check("full_px", px_cnt, 32);
        check("full_addr", addr, BASE); check("full_write", write, 1);
        @(posedge clk); #1 stall_mode = 0;
      end
    join
    wait_done(8);
    check("q_empty_3", exp_a.size(), 0);
    stall_mode = 2;
    for (int c = 0; c < W; c++) send_pixel(12'(c + 1), c == 0, c == W - 1);
    begin
      int n = 0;
      while (!write && n < 50) begin @(posedge clk); #1; n++; end
      check("mid_burst", write, 1);
    end
    rst_n = 0;
    @(posedge clk); @(negedge clk);
    check("mrst_write", write, 0); check("mrst_addr", addr, BASE); check("mrst_wdata", wdata, 0);
    check("mrst_busy", busy, 0); check("mrst_ready", ready, 0); check("mrst_err", err, 0);
    @(posedge clk); #1 rst_n = 1; stall_mode = 1; gap_en = 1;
    send_frame(); wait_done(9);
    check("q_empty_4", exp_a.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
